// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies,
// FSM state type and a small issue-decode helper.
package mdu_pkg;

   localparam logic [3:0] OpNone  = 4'd0;
   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMfhi  = 4'd5;
   localparam logic [3:0] OpMflo  = 4'd6;
   localparam logic [3:0] OpMthi  = 4'd7;
   localparam logic [3:0] OpMtlo  = 4'd8;

   localparam int unsigned MultCyclesDef = 5;
   localparam int unsigned DivCyclesDef  = 10;
   localparam int unsigned CntW          = 8;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } mdu_state_e;

   function automatic logic is_issue_op(input logic [3:0] op);
      return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
   endfunction

   function automatic logic is_mult_op(input logic [3:0] op);
      return (op == OpMult) || (op == OpMultu);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic for the MDU: 64-bit product or {remainder, quotient},
// plus a divide-by-zero flag. The controller only registers what this produces.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] result_o,
   output logic        div0_o
);

   logic        signed_op;
   logic        a_neg;
   logic        b_neg;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] quo_s;
   logic [31:0] rem_s;

   always_comb begin
      signed_op = (op_i == OpMult) || (op_i == OpDiv);
      a_neg     = signed_op & a_i[31];
      b_neg     = signed_op & b_i[31];
      // Sign- or zero-extend so one 64-bit multiplier serves both flavours.
      a_ext     = {{32{a_neg}}, a_i};
      b_ext     = {{32{b_neg}}, b_i};
      prod      = a_ext * b_ext;

      a_mag = a_neg ? (32'd0 - a_i) : a_i;
      b_mag = b_neg ? (32'd0 - b_i) : b_i;
      quo   = '0;
      rem   = '0;
      if (b_mag != 32'd0) begin
         quo = a_mag / b_mag;
         rem = a_mag % b_mag;
      end
      // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to itself).
      quo_s = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
      rem_s = a_neg ? (32'd0 - rem) : rem;

      result_o = '0;
      div0_o   = 1'b0;
      case (op_i)
         OpMult, OpMultu: result_o = prod;
         OpDiv, OpDivu: begin
            result_o = {rem_s, quo_s};
            div0_o   = (b_i == 32'd0);
         end
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: latches the result at issue, models the pipeline
// latency with a down-counter, then commits to HI/LO with a one-cycle done pulse.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MultCyclesDef,
   parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_hi,
   output logic [31:0] data_lo
);

   mdu_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   logic [63:0]     res_q, res_d;
   logic            div0_q, div0_d;

   logic [63:0]     calc_res;
   logic            calc_div0;

   mdu_calc u_calc (
      .op_i     (op),
      .a_i      (in_a),
      .b_i      (in_b),
      .result_o (calc_res),
      .div0_o   (calc_div0)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      div0_d  = div0_q;

      unique case (state_q)
         StIdle: begin
            if (!req) begin
               if (start && is_issue_op(op)) begin
                  state_d = StRun;
                  busy_d  = 1'b1;
                  cnt_d   = is_mult_op(op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                  res_d   = calc_res;
                  div0_d  = calc_div0;
               end else if (op == OpMthi) begin
                  hi_d = in_a;
               end else if (op == OpMtlo) begin
                  lo_d = in_a;
               end
            end
         end
         StRun: begin
            // req is deliberately not looked at here: the older instruction completes.
            if (cnt_q <= CntW'(1)) begin
               state_d = StIdle;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (!div0_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         div0_q  <= div0_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign data_hi = hi_q;
   assign data_lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: a transaction-level model checked every cycle, plus directed
// vectors with hand-computed HI/LO values.
module tb_mdu_ctrl;

   localparam int MultLat = 5;
   localparam int DivLat  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] data_hi;
   logic [31:0] data_lo;

   int tests = 0;
   int fails = 0;

   mdu_ctrl #(
      .MULT_CYCLES (MultLat),
      .DIV_CYCLES  (DivLat)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .start   (start),
      .op      (op),
      .in_a    (in_a),
      .in_b    (in_b),
      .busy    (busy),
      .done    (done),
      .data_hi (data_hi),
      .data_lo (data_lo)
   );

   always #5 clk = ~clk;

   // Reference arithmetic straight from the instruction semantics.
   function automatic logic [63:0] golden(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, output bit dz);
      longint          sa, sb;
      longint unsigned ua, ub;
      int              ia, ib, q, r;
      dz = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      case (o)
         4'd1: return 64'(sa * sb);
         4'd2: return 64'(ua * ub);
         4'd3: begin
            if (b == 0) begin
               dz = 1;
               return 64'd0;
            end
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = ia / ib;
            r = ia % ib;
            return {32'(r), 32'(q)};
         end
         4'd4: begin
            if (b == 0) begin
               dz = 1;
               return 64'd0;
            end
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Model: cycles left in flight, pending result, architectural HI/LO.
   int          m_left = 0;
   bit          m_done = 0;
   bit          p_dz = 0;
   logic [63:0] p_res = '0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_left = 0;
         m_done = 0;
         p_res  = '0;
         p_dz   = 0;
         m_hi   = '0;
         m_lo   = '0;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_done = 1;
               if (!p_dz) begin
                  m_hi = p_res[63:32];
                  m_lo = p_res[31:0];
               end
            end
         end else if (!req) begin
            if (start && op >= 4'd1 && op <= 4'd4) begin
               p_res  = golden(op, in_a, in_b, p_dz);
               m_left = (op <= 4'd2) ? MultLat : DivLat;
            end else if (op == 4'd7) begin
               m_hi = in_a;
            end else if (op == 4'd8) begin
               m_lo = in_a;
            end
         end
      end
   end

   always @(negedge clk) begin
      tests++;
      if (busy !== (m_left > 0) || done !== m_done || data_hi !== m_hi || data_lo !== m_lo) begin
         fails++;
         $display("FAIL model t=%0t busy/done/hi/lo got %b/%b/%h/%h want %b/%b/%h/%h", $time,
                  busy, done, data_hi, data_lo, m_left > 0, m_done, m_hi, m_lo);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Issue an op and follow it to the cycle busy falls (ends on that negedge).
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output logic saw_done);
      nbusy = 0;
      saw_done = 1'b0;
      step();
      start = 1'b1;
      op = o;
      in_a = a;
      in_b = b;
      step();
      start = 1'b0;
      op = 4'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         else begin
            saw_done = done;
            break;
         end
      end
   endtask

   task automatic move_to(input logic [3:0] o, input logic [31:0] a, input logic r);
      step();
      op = o;
      in_a = a;
      req = r;
      step();
      op = 4'd0;
      req = 1'b0;
   endtask

   int   nb;
   logic dn;

   initial begin
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", data_hi, 32'd0);
      check("reset_lo", data_lo, 32'd0);
      #20;
      reset = 1'b1;

      run_op(4'd1, 32'hFFFF_FFFE, 32'h0000_0003, nb, dn);
      check("mult_busy_cycles", nb, 32'd5);
      check("mult_done", {31'd0, dn}, 32'd1);
      check("mult_hi", data_hi, 32'hFFFF_FFFF);
      check("mult_lo", data_lo, 32'hFFFF_FFFA);

      run_op(4'd4, 32'd7, 32'd2, nb, dn);
      check("divu_busy_cycles", nb, 32'd10);
      check("divu_lo", data_lo, 32'd3);
      check("divu_hi", data_hi, 32'd1);

      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb, dn);
      check("div_neg_lo", data_lo, 32'hFFFF_FFFD);
      check("div_neg_hi", data_hi, 32'hFFFF_FFFF);

      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb, dn);
      check("div_ovf_lo", data_lo, 32'h8000_0000);
      check("div_ovf_hi", data_hi, 32'd0);

      move_to(4'd7, 32'h1234_5678, 1'b1);
      check("mthi_req_hi", data_hi, 32'd0);
      move_to(4'd7, 32'h1234_5678, 1'b0);
      check("mthi_hi", data_hi, 32'h1234_5678);

      // MULT with req pulsed in busy cycle 2: the older op still completes.
      step();
      start = 1'b1;
      op = 4'd1;
      in_a = 32'd6;
      in_b = 32'd7;
      step();
      start = 1'b0;
      op = 4'd0;
      nb = 1;
      step();
      req = 1'b1;
      nb++;
      step();
      req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
         nb++;
      end
      check("req_mult_busy_cycles", nb, 32'd5);
      check("req_mult_done", {31'd0, done}, 32'd1);
      check("req_mult_lo", data_lo, 32'd42);

      step();
      start = 1'b1;
      op = 4'd1;
      req = 1'b1;
      step();
      start = 1'b0;
      op = 4'd0;
      req = 1'b0;
      check("start_req_busy", {31'd0, busy}, 32'd0);

      move_to(4'd7, 32'hA5A5_A5A5, 1'b0);
      move_to(4'd8, 32'hA5A5_A5A5, 1'b0);
      run_op(4'd3, 32'd9, 32'd0, nb, dn);
      check("div0_busy_cycles", nb, 32'd10);
      check("div0_done", {31'd0, dn}, 32'd1);
      check("div0_hi", data_hi, 32'hA5A5_A5A5);
      check("div0_lo", data_lo, 32'hA5A5_A5A5);

      // Back-to-back: issue in the very cycle busy falls.
      run_op(4'd2, 32'd10, 32'd10, nb, dn);
      check("b2b_first_lo", data_lo, 32'd100);
      start = 1'b1;
      op = 4'd2;
      in_a = 32'd4;
      in_b = 32'd5;
      step();
      start = 1'b0;
      op = 4'd0;
      check("b2b_accept_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("b2b_second_lo", data_lo, 32'd20);

      // Reset in busy cycle 3 of a DIV.
      step();
      start = 1'b1;
      op = 4'd3;
      in_a = 32'd100;
      in_b = 32'd7;
      step();
      start = 1'b0;
      op = 4'd0;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_hi", data_hi, 32'd0);
      check("rst_mid_lo", data_lo, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      step();
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) check("rst_no_done", {31'd0, done}, 32'd0);
      end
      run_op(4'd2, 32'd2, 32'd3, nb, dn);
      check("post_rst_busy_cycles", nb, 32'd5);
      check("post_rst_lo", data_lo, 32'd6);
      check("post_rst_hi", data_hi, 32'd0);

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
